// File: rtl/pri_encoder_scan.sv
// pri_encoder_scan: handshaked priority scanner. Accepts a request vector,
// then emits the index of every set bit (one per beat) in priority order,
// clearing each bit as it is consumed. An all-zero vector yields a single
// beat flagged out_none. Priority encode and the "at most one bit left"
// test share one log-depth reduction tree so wide vectors stay shallow.
module pri_encoder_scan #(
    parameter int WIDTH     = 16,
    parameter int MSB_FIRST = 0,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             out_none
);

    // Tree leaves are padded to the next power of two; pad bits are never set.
    localparam int PAD = 1 << IDX_W;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] pending;
    logic             zero_flag;

    logic             scan;
    logic             take;
    logic             xfer;
    logic [IDX_W-1:0] root_idx;
    logic             root_multi;
    logic [WIDTH-1:0] clr_mask;

    // Reduction tree: each node carries "any bit set", "more than one bit
    // set" and the index of its winning bit. A node's index gains bit (l-1)
    // when the winner comes from the upper child.
    for (genvar l = 0; l <= IDX_W; l++) begin : lvl
        localparam int N = PAD >> l;
        logic [N-1:0]     node_any;
        logic [N-1:0]     node_multi;
        logic [IDX_W-1:0] node_idx [N];

        if (l == 0) begin : leaf
            for (genvar i = 0; i < N; i++) begin : leaf_bit
                if (i < WIDTH) begin : real_bit
                    assign node_any[i] = pending[i];
                end else begin : pad_bit
                    assign node_any[i] = 1'b0;
                end
                assign node_multi[i] = 1'b0;
                assign node_idx[i]   = '0;
            end
        end else begin : inner
            for (genvar j = 0; j < N; j++) begin : pair
                logic lo_any;
                logic hi_any;
                logic sel_hi;
                assign lo_any = lvl[l-1].node_any[2*j];
                assign hi_any = lvl[l-1].node_any[2*j+1];
                // Upper child wins when it has priority and a set bit, or
                // when the lower child is empty.
                assign sel_hi = (MSB_FIRST != 0) ? hi_any : !lo_any;
                assign node_any[j]   = lo_any | hi_any;
                assign node_multi[j] = lvl[l-1].node_multi[2*j]
                                     | lvl[l-1].node_multi[2*j+1]
                                     | (lo_any & hi_any);
                assign node_idx[j]   = sel_hi
                                     ? (lvl[l-1].node_idx[2*j+1] | (IDX_W'(1) << (l-1)))
                                     : lvl[l-1].node_idx[2*j];
            end
        end
    end

    assign root_idx   = lvl[IDX_W].node_idx[0];
    assign root_multi = lvl[IDX_W].node_multi[0];

    // Handshake and output decode; all outputs forced low while reset is high.
    always_comb begin
        scan      = (state == SCAN) && !reset;
        out_valid = scan;
        out_last  = scan && !root_multi;
        out_none  = scan && zero_flag;
        out_index = (scan && !zero_flag) ? root_idx : '0;
        in_ready  = !reset && ((state == IDLE) || (scan && out_ready && out_last));
        take      = in_valid && in_ready;
        xfer      = out_valid && out_ready;
        clr_mask  = {{(WIDTH-1){1'b0}}, 1'b1} << out_index;
    end

    // Scan state: load on accept, clear the emitted bit on each transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= '0;
            zero_flag <= 1'b0;
        end else if (take) begin
            state     <= SCAN;
            pending   <= in_vec;
            zero_flag <= (in_vec == '0);
        end else if (xfer) begin
            if (!zero_flag) begin
                pending <= pending & ~clr_mask;
            end
            if (out_last) begin
                state     <= IDLE;
                zero_flag <= 1'b0;
            end
        end
    end

endmodule
